// File: rtl/warp_scheduler_if.sv
// Issue, commit and memory-completion signals shared by the warp scheduler
// (master) and the fetch/decode front end plus execute units (slave).
interface warp_scheduler_if #(
    parameter int NUM_WARPS = 4,
    parameter int PC_BITS   = 12
);
    localparam int WID_BITS = $clog2(NUM_WARPS);

    logic                issue_valid;
    logic [WID_BITS-1:0] issue_warp;
    logic [PC_BITS-1:0]  issue_pc;
    logic                issue_ready;

    logic                commit_valid;
    logic [WID_BITS-1:0] commit_warp;
    logic [PC_BITS-1:0]  commit_next_pc;
    logic                commit_mem;
    logic                commit_ret;

    logic                mem_done_valid;
    logic [WID_BITS-1:0] mem_done_warp;

    modport master (
        output issue_valid, issue_warp, issue_pc,
        input  issue_ready,
        input  commit_valid, commit_warp, commit_next_pc, commit_mem, commit_ret,
        input  mem_done_valid, mem_done_warp
    );

    modport slave (
        input  issue_valid, issue_warp, issue_pc,
        output issue_ready,
        output commit_valid, commit_warp, commit_next_pc, commit_mem, commit_ret,
        output mem_done_valid, mem_done_warp
    );
endinterface

// File: rtl/warp_scheduler.sv
// Round-robin multi-warp issue scheduler: each warp has its own PC and skips
// issue while waiting on data memory so other warps can hide LSU latency.
module warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int PC_BITS   = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_WARPS-1:0] warp_enable,
    input  logic [PC_BITS-1:0]   base_pc,
    warp_scheduler_if.master     bus,
    output logic                 done,
    output logic                 protocol_error,
    output logic [31:0]          idle_cycles
);
    localparam int WID_BITS = $clog2(NUM_WARPS);

    typedef enum logic [1:0] {IDLE, RUN, FINISHED} top_state_t;
    typedef enum logic [2:0] {W_IDLE, W_READY, W_ISSUED, W_WAIT_MEM, W_DONE} warp_state_t;

    top_state_t          top_state;
    warp_state_t         wstate    [NUM_WARPS];
    warp_state_t         wstate_nx [NUM_WARPS];
    logic [PC_BITS-1:0]  pc        [NUM_WARPS];
    logic [PC_BITS-1:0]  pc_nx     [NUM_WARPS];
    logic [WID_BITS-1:0] rr_ptr;

    logic                issue_valid_q;
    logic [WID_BITS-1:0] issue_warp_q;
    logic [PC_BITS-1:0]  issue_pc_q;

    logic                accept;
    logic                event_error;
    logic                any_ready;
    logic                all_finished;
    logic                sel_found;
    logic [WID_BITS-1:0] sel_warp;
    logic [WID_BITS-1:0] search_base;
    logic [WID_BITS-1:0] probe;
    logic [NUM_WARPS-1:0] candidates;

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_warp  = issue_warp_q;
    assign bus.issue_pc    = issue_pc_q;

    // Legality of commit and mem_done is judged on the pre-edge warp state.
    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            wstate_nx[i] = wstate[i];
            pc_nx[i]     = pc[i];
        end
        event_error = 1'b0;
        accept      = issue_valid_q && bus.issue_ready;

        if (accept) begin
            wstate_nx[issue_warp_q] = W_ISSUED;
        end

        if (bus.commit_valid) begin
            if (wstate[bus.commit_warp] == W_ISSUED) begin
                if (bus.commit_ret) begin
                    wstate_nx[bus.commit_warp] = W_DONE;
                end else if (bus.commit_mem) begin
                    wstate_nx[bus.commit_warp] = W_WAIT_MEM;
                    pc_nx[bus.commit_warp]     = bus.commit_next_pc;
                end else begin
                    wstate_nx[bus.commit_warp] = W_READY;
                    pc_nx[bus.commit_warp]     = bus.commit_next_pc;
                end
            end else begin
                event_error = 1'b1;
            end
        end

        if (bus.mem_done_valid) begin
            if (wstate[bus.mem_done_warp] == W_WAIT_MEM) begin
                wstate_nx[bus.mem_done_warp] = W_READY;
            end else begin
                event_error = 1'b1;
            end
        end
    end

    // The warp being accepted this edge is excluded so the next pick can go out back-to-back.
    always_comb begin
        any_ready  = 1'b0;
        candidates = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (wstate[i] == W_READY) begin
                any_ready     = 1'b1;
                candidates[i] = !(accept && (issue_warp_q == WID_BITS'(i)));
            end
        end

        search_base = accept ? (issue_warp_q + WID_BITS'(1)) : rr_ptr;
        sel_found   = 1'b0;
        sel_warp    = '0;
        probe       = '0;
        for (int k = NUM_WARPS - 1; k >= 0; k--) begin
            probe = search_base + WID_BITS'(k);
            if (candidates[probe]) begin
                sel_found = 1'b1;
                sel_warp  = probe;
            end
        end

        all_finished = 1'b1;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!(wstate_nx[i] == W_IDLE || wstate_nx[i] == W_DONE)) begin
                all_finished = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_state      <= IDLE;
            for (int i = 0; i < NUM_WARPS; i++) begin
                wstate[i] <= W_IDLE;
                pc[i]     <= '0;
            end
            rr_ptr         <= '0;
            issue_valid_q  <= 1'b0;
            issue_warp_q   <= '0;
            issue_pc_q     <= '0;
            done           <= 1'b0;
            protocol_error <= 1'b0;
            idle_cycles    <= '0;
        end else begin
            protocol_error <= protocol_error | event_error;
            for (int i = 0; i < NUM_WARPS; i++) begin
                wstate[i] <= wstate_nx[i];
                pc[i]     <= pc_nx[i];
            end

            case (top_state)
                IDLE, FINISHED: begin
                    if (start) begin
                        for (int i = 0; i < NUM_WARPS; i++) begin
                            wstate[i] <= warp_enable[i] ? W_READY : W_IDLE;
                            pc[i]     <= base_pc;
                        end
                        rr_ptr        <= '0;
                        idle_cycles   <= '0;
                        issue_valid_q <= 1'b0;
                        if (warp_enable == '0) begin
                            top_state <= FINISHED;
                            done      <= 1'b1;
                        end else begin
                            top_state <= RUN;
                            done      <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        rr_ptr <= issue_warp_q + WID_BITS'(1);
                    end
                    if (!issue_valid_q || accept) begin
                        issue_valid_q <= sel_found;
                        if (sel_found) begin
                            issue_warp_q <= sel_warp;
                            issue_pc_q   <= pc[sel_warp];
                        end
                    end
                    if (!any_ready && !issue_valid_q && (idle_cycles != '1)) begin
                        idle_cycles <= idle_cycles + 32'd1;
                    end
                    if (all_finished) begin
                        top_state <= FINISHED;
                        done      <= 1'b1;
                    end
                end
                default: top_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Multi-warp instruction-issue scheduler for the compute core; generalises the single-PC, one-block-at-a-time core scheduling to NUM_WARPS independent warps, each with its own PC.
- Warps waiting on data memory are skipped so other warps can issue, which hides LSU latency.
- Sits between the fetcher/decoder front end (issue side) and the per-thread execute units (commit and memory-completion side).

Parameters:
- NUM_WARPS, 4, number of independently scheduled warps (power of two, ≥2).
- PC_BITS, 12, program counter width (matches PROGRAM_MEM_ADDR_BITS).
- WID_BITS, $clog2(NUM_WARPS), warp-index width (derived; never overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch pulse; sampled only in IDLE or FINISHED.
- warp_enable  in  NUM_WARPS  warps participating in the launch; sampled on start.
- base_pc  in  PC_BITS  initial PC for every enabled warp; sampled on start.
- issue_valid  out  1  issue request valid.
- issue_warp  out  WID_BITS  warp being issued.
- issue_pc  out  PC_BITS  PC of the issued warp.
- issue_ready  in  1  front end accepts the issue.
- commit_valid  in  1  an issued instruction has completed.
- commit_warp  in  WID_BITS  warp that completed.
- commit_next_pc  in  PC_BITS  next PC for that warp.
- commit_mem  in  1  instruction started a memory access; warp must wait.
- commit_ret  in  1  instruction was RET; warp finishes.
- mem_done_valid  in  1  memory access completed.
- mem_done_warp  in  WID_BITS  warp whose memory access completed.
- done  out  1  all enabled warps finished.
- protocol_error  out  1  sticky illegal-commit/mem_done flag.
- idle_cycles  out  32  saturating count of RUN cycles with nothing to issue.

Behaviour:
- Reset (asynchronous, active-low) takes effect immediately, mid-operation included:
  - issue_valid=0, issue_warp=0, issue_pc=0, done=0, protocol_error=0, idle_cycles=0.
  - All warps go to W_IDLE, all PCs to 0, round-robin pointer to 0, top FSM to IDLE.
  - An outstanding issue is dropped with no handshake.
- Top FSM:
  - IDLE --start--> RUN. Enabled warps go to W_READY with pc=base_pc; other warps go to W_IDLE.
  - RUN --(all enabled warps W_DONE)--> FINISHED. done=1 registered, i.e. in the cycle after the final ret commit.
  - warp_enable==0 at start: go to FINISHED directly, so done=1 in the cycle after start.
  - FINISHED holds done=1. FINISHED --start--> RUN with a fresh launch, done=0 from the next cycle.
  - start in RUN is ignored.
- Per-warp states: W_IDLE, W_READY, W_ISSUED, W_WAIT_MEM, W_DONE.
- Issue selection:
  - Runs when issue_valid=0, or in the same cycle issue_valid&&issue_ready fires.
  - Picks the first W_READY warp at or after the round-robin pointer, with wrap-around.
  - issue_valid, issue_warp and issue_pc are registered, so a warp made READY at edge t can appear on issue_valid at edge t+1.
  - On acceptance (valid&&ready at an edge): the warp goes to W_ISSUED and pointer = issue_warp+1 mod NUM_WARPS.
  - A replacement issue may appear in the following cycle (back-to-back, 1 issue/cycle).
  - While issue_valid=1 and issue_ready=0, all three issue outputs stay stable.
- Commit (commit_valid=1), legal only when commit_warp is in W_ISSUED:
  - commit_ret=1 → W_DONE; this has priority over commit_mem.
  - commit_mem=1 → W_WAIT_MEM, pc=commit_next_pc.
  - otherwise → W_READY, pc=commit_next_pc.
  - Illegal commit: no state or PC change, protocol_error←1.
- mem_done (mem_done_valid=1), legal only when mem_done_warp is in W_WAIT_MEM:
  - Warp goes to W_READY.
  - Illegal mem_done: ignored, protocol_error←1.
- Simultaneous events:
  - commit, mem_done and issue acceptance for different warps in one cycle all apply.
  - commit and mem_done for the same warp in one cycle: the commit applies; mem_done is evaluated against the pre-edge state and is therefore illegal.
- idle_cycles: increments in RUN when no warp is W_READY and issue_valid=0; saturates at 2^32-1; cleared on start.
- protocol_error clears only on reset.

Test Plan:
- Round-robin issue: enable=4'b1111, base_pc=0x010, issue_ready=1, each issue committed non-mem with next_pc=pc+1 → issue order 0,1,2,3,0,1,… with every warp's second issue at 0x011.
- Backpressure: issue_ready=0 for 5 cycles with warp 2 pending at pc=0x020 → issue_valid=1, issue_warp=2, issue_pc=0x020 unchanged all 5 cycles; accepted on the first ready cycle.
- Memory wait: warp 1 commits with commit_mem=1, next_pc=0x031 → warps 0,2,3 keep issuing and warp 1 is skipped; mem_done_warp=1 → warp 1 re-issues at 0x031 within 2 cycles.
- Completion: all four warps commit_ret=1 → done=1 the cycle after the last commit; done stays 1 until start; enable=4'b0000 with start → done=1 the next cycle.
- Errors and idle counting: commit for a W_READY warp → protocol_error=1 and state unchanged; with all warps in W_WAIT_MEM for 10 cycles → idle_cycles=10.
- Async reset mid-run: assert reset low between clock edges with issue_valid=1 → all outputs 0 immediately; after release, the next start relaunches cleanly.
